// File: rtl/recover_2n_ctrl.sv
// recover_2n_ctrl: read sequencer for the 2N-point recovery datapath.
// Walks the two N-point CFFT result buffers (x1/x2 share addresses) with
// two column-1-only head beats followed by paired column-1/column-2 beats,
// and delays the beat indices by RD_LAT enabled cycles so they line up with
// buffer read data. A downstream stall freezes the whole schedule.
// Optional feature macro: RECOVER_CTRL_PERF_EN adds a saturating stall_cnt.
module recover_2n_ctrl #(
  parameter int N_POINTS = 8192,
  parameter int LANES    = 4,
  parameter int RD_LAT   = 1,
  parameter int IDX_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             start_rdy,
  input  logic             stall,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr_c1,
  output logic [IDX_W-1:0] rd_addr_c2,
  output logic             rd_c2_en,
  output logic             dp_valid,
  output logic [IDX_W-1:0] dp_index_col_1,
  output logic [IDX_W-1:0] dp_index_col_2,
  output logic             dp_col2_vld,
  output logic             busy,
  output logic             done
`ifdef RECOVER_CTRL_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int               WORDS      = N_POINTS / LANES;
  // Last beat counter value of a frame: beats 0..WORDS/2 inclusive.
  localparam logic [IDX_W:0]   LAST_B     = (IDX_W+1)'(WORDS / 2);
  localparam logic [IDX_W:0]   B_ONE      = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] A_ONE      = IDX_W'(1);
  localparam logic [1:0]       DRAIN_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD  = 3'd1,
    S_BODY  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [IDX_W:0]   b_q;
  logic [1:0]       drain_q;
  logic             busy_q;
  logic             done_q;
  logic             start_rdy_q;

  // Issue-side beat decode (current cycle, gated by stall).
  logic             issue;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] iss_c1;
  logic [IDX_W-1:0] iss_c2;
  logic             iss_c2en;

  // Delay pipeline carrying the beat towards the datapath.
  logic             pv_q   [RD_LAT];
  logic [IDX_W-1:0] pc1_q  [RD_LAT];
  logic [IDX_W-1:0] pc2_q  [RD_LAT];
  logic             pc2v_q [RD_LAT];

  // Decode the beat issued this cycle from state and beat counter.
  always_comb begin
    issue    = 1'b0;
    iss_c1   = '0;
    iss_c2   = '0;
    iss_c2en = 1'b0;
    base     = b_q[IDX_W-1:0] - A_ONE;
    case (state_q)
      S_HEAD: begin
        if (!stall) begin
          issue  = 1'b1;
          iss_c1 = b_q[IDX_W-1:0];
        end else begin
          issue  = 1'b0;
        end
      end
      S_BODY: begin
        if (!stall) begin
          issue    = 1'b1;
          iss_c1   = base << 1'b1;
          iss_c2   = (base << 1'b1) | A_ONE;
          iss_c2en = 1'b1;
        end else begin
          issue    = 1'b0;
        end
      end
      default: begin
        issue = 1'b0;
      end
    endcase
  end

  // Frame sequencer: state, beat counter, drain counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      b_q         <= '0;
      drain_q     <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_rdy_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_HEAD;
            b_q         <= '0;
            drain_q     <= 2'd0;
            busy_q      <= 1'b1;
            start_rdy_q <= 1'b0;
          end
        end
        S_HEAD: begin
          if (!stall) begin
            b_q <= b_q + B_ONE;
            if (b_q == B_ONE) begin
              state_q <= S_BODY;
            end
          end
        end
        S_BODY: begin
          if (!stall) begin
            if (b_q == LAST_B) begin
              state_q <= S_DRAIN;
              drain_q <= 2'd0;
            end else begin
              b_q <= b_q + B_ONE;
            end
          end
        end
        S_DRAIN: begin
          // Wait for RD_LAT advancing cycles so the pipeline empties.
          if (!stall) begin
            if (drain_q == DRAIN_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              drain_q <= drain_q + 2'd1;
            end
          end
        end
        S_DONE: begin
          // Stall is ignored here; start in this cycle is not accepted.
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          start_rdy_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          b_q         <= '0;
          drain_q     <= 2'd0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          start_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  // Index delay line; advances only on non-stalled cycles so the beat at
  // the datapath output is re-presented after a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i]   <= 1'b0;
        pc1_q[i]  <= '0;
        pc2_q[i]  <= '0;
        pc2v_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      pv_q[0]   <= issue;
      pc1_q[0]  <= iss_c1;
      pc2_q[0]  <= iss_c2;
      pc2v_q[0] <= iss_c2en;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        pc1_q[i]  <= pc1_q[i-1];
        pc2_q[i]  <= pc2_q[i-1];
        pc2v_q[i] <= pc2v_q[i-1];
      end
    end
  end

  assign rd_en          = issue;
  assign rd_addr_c1     = iss_c1;
  assign rd_addr_c2     = iss_c2;
  assign rd_c2_en       = iss_c2en;
  assign dp_valid       = pv_q[RD_LAT-1] & ~stall;
  assign dp_index_col_1 = pc1_q[RD_LAT-1];
  assign dp_index_col_2 = pc2_q[RD_LAT-1];
  assign dp_col2_vld    = pc2v_q[RD_LAT-1];
  assign busy           = busy_q;
  assign done           = done_q;
  assign start_rdy      = start_rdy_q;

`ifdef RECOVER_CTRL_PERF_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stalled busy cycles, restarted per accepted frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (state_q == S_IDLE && start) begin
      stall_cnt_q <= 16'd0;
    end else if (busy_q && stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_recover_2n_ctrl.sv
// Directed bench for recover_2n_ctrl: one default instance (RD_LAT=1,
// 1025-beat frames) and one small instance (N_POINTS=64, RD_LAT=3).
module tb_recover_2n_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, stall0, start1, stall1;

  logic        start_rdy0, rd_en0, rd_c2_en0, dp_valid0, dp_col2_vld0, busy0, done0;
  logic [10:0] rd_addr_c1_0, rd_addr_c2_0, dp_index_col_1_0, dp_index_col_2_0;
  logic        start_rdy1, rd_en1, rd_c2_en1, dp_valid1, dp_col2_vld1, busy1, done1;
  logic [3:0]  rd_addr_c1_1, rd_addr_c2_1, dp_index_col_1_1, dp_index_col_2_1;
`ifdef RECOVER_CTRL_PERF_EN
  logic [15:0] stall_cnt0, stall_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  recover_2n_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start0), .start_rdy(start_rdy0), .stall(stall0),
    .rd_en(rd_en0), .rd_addr_c1(rd_addr_c1_0), .rd_addr_c2(rd_addr_c2_0),
    .rd_c2_en(rd_c2_en0), .dp_valid(dp_valid0), .dp_index_col_1(dp_index_col_1_0),
    .dp_index_col_2(dp_index_col_2_0), .dp_col2_vld(dp_col2_vld0), .busy(busy0),
    .done(done0)
`ifdef RECOVER_CTRL_PERF_EN
    , .stall_cnt(stall_cnt0)
`endif
  );

  recover_2n_ctrl #(.N_POINTS(64), .LANES(4), .RD_LAT(3), .IDX_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .start_rdy(start_rdy1), .stall(stall1),
    .rd_en(rd_en1), .rd_addr_c1(rd_addr_c1_1), .rd_addr_c2(rd_addr_c2_1),
    .rd_c2_en(rd_c2_en1), .dp_valid(dp_valid1), .dp_index_col_1(dp_index_col_1_1),
    .dp_index_col_2(dp_index_col_2_1), .dp_col2_vld(dp_col2_vld1), .busy(busy1),
    .done(done1)
`ifdef RECOVER_CTRL_PERF_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  // Hand-derived beat j of a default frame: {col2_en, col1_addr, col2_addr}.
  function automatic logic [22:0] beat0(input int j);
    logic [10:0] a;
    if (j < 2) begin
      beat0 = {1'b0, 11'(j), 11'd0};
    end else begin
      a     = 11'(2 * (j - 1));
      beat0 = {1'b1, a, a | 11'd1};
    end
  endfunction

  // Same for the 64-point instance (4-bit indices).
  function automatic logic [8:0] beat1(input int j);
    logic [3:0] a;
    if (j < 2) begin
      beat1 = {1'b0, 4'(j), 4'd0};
    end else begin
      a     = 4'(2 * (j - 1));
      beat1 = {1'b1, a, a | 4'd1};
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start0 = 1'b0; stall0 = 1'b0; start1 = 1'b0; stall1 = 1'b0;
    tick; tick;
    rst = 1'b0;
    #1;
    total++;
    if ({start_rdy0, busy0, rd_en0, rd_c2_en0, dp_valid0, dp_col2_vld0, done0} !== 7'b1000000) begin
      bad++; $display("FAIL reset_flags0 got=%b exp=1000000",
        {start_rdy0, busy0, rd_en0, rd_c2_en0, dp_valid0, dp_col2_vld0, done0});
    end
    total++;
    if ({rd_addr_c1_0, rd_addr_c2_0, dp_index_col_1_0, dp_index_col_2_0} !== 44'd0) begin
      bad++; $display("FAIL reset_idx0 got=%h exp=0",
        {rd_addr_c1_0, rd_addr_c2_0, dp_index_col_1_0, dp_index_col_2_0});
    end
    total++;
    if ({start_rdy1, busy1, rd_en1, rd_c2_en1, dp_valid1, dp_col2_vld1, done1} !== 7'b1000000) begin
      bad++; $display("FAIL reset_flags1 got=%b exp=1000000",
        {start_rdy1, busy1, rd_en1, rd_c2_en1, dp_valid1, dp_col2_vld1, done1});
    end
    total++;
    if ({rd_addr_c1_1, rd_addr_c2_1, dp_index_col_1_1, dp_index_col_2_1} !== 16'd0) begin
      bad++; $display("FAIL reset_idx1 got=%h exp=0",
        {rd_addr_c1_1, rd_addr_c2_1, dp_index_col_1_1, dp_index_col_2_1});
    end
    tick;
  endtask

  task automatic test_single_frame;
    logic [48:0] exp_v, got_v;
    logic [22:0] iss, dpb;
    start0 = 1'b1;
    #1;
    total++;
    if (start_rdy0 !== 1'b1) begin
      bad++; $display("FAIL start_rdy_idle got=%b exp=1", start_rdy0);
    end
    tick;
    start0 = 1'b0;
    for (int c = 0; c <= 1026; c++) begin
      #1;
      iss   = (c < 1025) ? beat0(c) : 23'd0;
      dpb   = (c >= 1 && c <= 1025) ? beat0(c - 1) : 23'd0;
      exp_v = {(c < 1025), iss, (c >= 1 && c <= 1025), dpb, (c == 1026)};
      got_v = {rd_en0, rd_c2_en0, rd_addr_c1_0, rd_addr_c2_0, dp_valid0, dp_col2_vld0,
               dp_index_col_1_0, dp_index_col_2_0, done0};
      total++;
      if (got_v !== exp_v) begin
        bad++; $display("FAIL frame_cycle%0d got=%h exp=%h", c, got_v, exp_v);
      end
      tick;
    end
    #1;
    total++;
    if ({busy0, start_rdy0} !== 2'b01) begin
      bad++; $display("FAIL frame_idle got=%b exp=01", {busy0, start_rdy0});
    end
    tick;
  endtask

  task automatic test_rd_lat3;
    logic [20:0] exp_v, got_v;
    logic [8:0]  iss, dpb;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      #1;
      iss   = (c < 9) ? beat1(c) : 9'd0;
      dpb   = (c >= 3 && c <= 11) ? beat1(c - 3) : 9'd0;
      exp_v = {(c < 9), iss, (c >= 3 && c <= 11), dpb, (c == 12)};
      got_v = {rd_en1, rd_c2_en1, rd_addr_c1_1, rd_addr_c2_1, dp_valid1, dp_col2_vld1,
               dp_index_col_1_1, dp_index_col_2_1, done1};
      total++;
      if (got_v !== exp_v) begin
        bad++; $display("FAIL lat3_cycle%0d got=%h exp=%h", c, got_v, exp_v);
      end
      tick;
    end
  endtask

  task automatic test_stall;
    int vcnt = 0, cnt100 = 0, done_cyc = -1, dcnt = 0, last_v = -1;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int c = 0; c <= 1034; c++) begin
      stall0 = (c >= 52 && c < 57);
      #1;
      if (dp_valid0) begin
        vcnt++; last_v = c;
        if (dp_index_col_1_0 == 11'd100) cnt100++;
      end
      if (done0) begin
        dcnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c >= 52 && c < 57) begin
        total++;
        if ({rd_en0, dp_valid0, dp_index_col_1_0, dp_index_col_2_0} !== {1'b0, 1'b0, 11'd100, 11'd101}) begin
          bad++; $display("FAIL stall_hold_cycle%0d got=%b,%b,%0d,%0d exp=0,0,100,101",
            c, rd_en0, dp_valid0, dp_index_col_1_0, dp_index_col_2_0);
        end
      end
      if (c == 57) begin
        total++;
        if ({rd_en0, rd_addr_c1_0, dp_valid0, dp_index_col_1_0, dp_index_col_2_0} !==
            {1'b1, 11'd102, 1'b1, 11'd100, 11'd101}) begin
          bad++; $display("FAIL stall_release got=%b,%0d,%b,%0d,%0d exp=1,102,1,100,101",
            rd_en0, rd_addr_c1_0, dp_valid0, dp_index_col_1_0, dp_index_col_2_0);
        end
      end
      tick;
    end
    stall0 = 1'b0;
    total++;
    if (vcnt != 1025) begin bad++; $display("FAIL stall_beats got=%0d exp=1025", vcnt); end
    total++;
    if (cnt100 != 1) begin bad++; $display("FAIL stall_once got=%0d exp=1", cnt100); end
    total++;
    if (last_v != 1030) begin bad++; $display("FAIL stall_last_valid got=%0d exp=1030", last_v); end
    total++;
    if (done_cyc != 1031 || dcnt != 1) begin
      bad++; $display("FAIL stall_done got=cyc%0d/n%0d exp=cyc1031/n1", done_cyc, dcnt);
    end
`ifdef RECOVER_CTRL_PERF_EN
    total++;
    if (stall_cnt0 !== 16'd5) begin bad++; $display("FAIL stall_cnt got=%0d exp=5", stall_cnt0); end
`endif
  endtask

  task automatic test_reset_mid;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int c = 0; c < 500; c++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    total++;
    if ({dp_valid0, busy0, start_rdy0, done0, rd_en0} !== 5'b00100) begin
      bad++; $display("FAIL rst_mid got=%b exp=00100", {dp_valid0, busy0, start_rdy0, done0, rd_en0});
    end
    tick;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if ({done0, busy0, dp_valid0} !== 3'b000) begin
        bad++; $display("FAIL rst_no_done got=%b exp=000", {done0, busy0, dp_valid0});
      end
      tick;
    end
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    #1;
    total++;
    if ({rd_en0, rd_c2_en0, rd_addr_c1_0} !== {1'b1, 1'b0, 11'd0}) begin
      bad++; $display("FAIL replay_issue got=%b,%b,%0d exp=1,0,0", rd_en0, rd_c2_en0, rd_addr_c1_0);
    end
    tick;
    #1;
    total++;
    if ({dp_valid0, dp_col2_vld0, dp_index_col_1_0, rd_addr_c1_0} !== {1'b1, 1'b0, 11'd0, 11'd1}) begin
      bad++; $display("FAIL replay_dp got=%b,%b,%0d,%0d exp=1,0,0,1",
        dp_valid0, dp_col2_vld0, dp_index_col_1_0, rd_addr_c1_0);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    int dcnt = 0, d1 = -1, d2 = -1;
    start0 = 1'b1;
    tick;
    for (int c = 0; c <= 2060; c++) begin
      if (c == 2045) start0 = 1'b0;
      #1;
      if (done0) begin
        dcnt++;
        if (dcnt == 1) d1 = c;
        else if (dcnt == 2) d2 = c;
      end
      if (c == 500) begin
        total++;
        if ({busy0, start_rdy0} !== 2'b10) begin
          bad++; $display("FAIL b2b_busy got=%b exp=10", {busy0, start_rdy0});
        end
      end
      if (c == 1027) begin
        total++;
        if ({rd_en0, start_rdy0, busy0} !== 3'b010) begin
          bad++; $display("FAIL b2b_gap got=%b exp=010", {rd_en0, start_rdy0, busy0});
        end
      end
      if (c == 1028) begin
        total++;
        if ({rd_en0, rd_addr_c1_0, busy0} !== {1'b1, 11'd0, 1'b1}) begin
          bad++; $display("FAIL b2b_restart got=%b,%0d,%b exp=1,0,1", rd_en0, rd_addr_c1_0, busy0);
        end
      end
      tick;
    end
    total++;
    if (dcnt != 2 || d1 != 1026 || d2 != 2054) begin
      bad++; $display("FAIL b2b_done got=n%0d,%0d,%0d exp=n2,1026,2054", dcnt, d1, d2);
    end
    #1;
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL b2b_end_idle got=%b exp=0", busy0); end
    tick;
  endtask

  task automatic test_stall_done_idle;
    int found = -1;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int c = 0; c < 12; c++) tick;
    stall1 = 1'b1;
    #1;
    total++;
    if (done1 !== 1'b1) begin bad++; $display("FAIL stall_in_done got=%b exp=1", done1); end
    tick;
    start1 = 1'b1;
    #1;
    total++;
    if ({done1, busy1, start_rdy1} !== 3'b001) begin
      bad++; $display("FAIL stall_idle got=%b exp=001", {done1, busy1, start_rdy1});
    end
    tick;
    start1 = 1'b0;
    for (int c = 14; c <= 16; c++) begin
      #1;
      total++;
      if ({busy1, start_rdy1, rd_en1, dp_valid1} !== 4'b1000) begin
        bad++; $display("FAIL head_wait_cycle%0d got=%b exp=1000", c, {busy1, start_rdy1, rd_en1, dp_valid1});
      end
      tick;
    end
    stall1 = 1'b0;
    #1;
    total++;
    if ({rd_en1, rd_c2_en1, rd_addr_c1_1} !== {1'b1, 1'b0, 4'd0}) begin
      bad++; $display("FAIL head_release got=%b,%b,%0d exp=1,0,0", rd_en1, rd_c2_en1, rd_addr_c1_1);
    end
`ifdef RECOVER_CTRL_PERF_EN
    total++;
    if (stall_cnt1 !== 16'd3) begin bad++; $display("FAIL stall_cnt_head got=%0d exp=3", stall_cnt1); end
`endif
    for (int c = 17; c <= 60 && found < 0; c++) begin
      if (done1) found = c;
      tick;
      #1;
    end
    total++;
    if (found != 29) begin bad++; $display("FAIL head_done got=%0d exp=29", found); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_rd_lat3;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    test_stall_done_idle;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/recover_2n_ctrl.md
Name: recover_2n_ctrl

Overview:
- Sequencer that feeds the 2N-point recovery datapath (recover_2n_FFT) from the two N-point CFFT result buffers, x1 and x2.
- Generates shared read addresses for both buffers and the beat schedule: two column-1-only head beats, then paired column-1/column-2 beats.
- Drives valid/index/col2-enable aligned with buffer read data, supports downstream stall, and signals frame completion.

Parameters:
- N_POINTS, 8192: complex points per CFFT buffer; power of two, at least 64.
- LANES, 4: complex samples per buffer word (one column).
- RD_LAT, 1: buffer read latency in cycles, range 1 to 4.
- IDX_W, 11: index and address width; equals log2(N_POINTS/LANES).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame request; honoured only while start_rdy=1
- start_rdy  out  1  1 in IDLE
- stall  in  1  downstream hold; freezes the schedule
- rd_en  out  1  buffer read enable; doubles as the buffer pipeline clock-enable
- rd_addr_c1  out  IDX_W  column-1 word address, x1 and x2 shared
- rd_addr_c2  out  IDX_W  column-2 word address, x1 and x2 shared
- rd_c2_en  out  1  column-2 read valid
- dp_valid  out  1  to recover_2n_FFT valid
- dp_index_col_1  out  IDX_W  to index_col_1
- dp_index_col_2  out  IDX_W  to index_col_2
- dp_col2_vld  out  1  column-2 lanes meaningful this beat
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the last beat is delivered

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all outputs 0 except start_rdy=1. State goes to IDLE, beat counter and delay pipeline clear.
- Reset mid-frame aborts with no done pulse. dp_valid is 0 from the following cycle.
- States: IDLE -> HEAD -> BODY -> DRAIN -> DONE -> IDLE.
- IDLE: on start=1, go to HEAD next cycle. The beat counter is B, width IDX_W+1.
- Issue schedule, one beat per non-stalled cycle. W = N_POINTS/LANES (2048).
  - HEAD, B=0: rd_addr_c1=0, rd_c2_en=0.
  - HEAD, B=1: rd_addr_c1=1, rd_c2_en=0. Then go to BODY.
  - BODY, B=k for k=2..W/2: rd_addr_c1=2(k-1), rd_addr_c2=2(k-1)+1, rd_c2_en=1.
  - After k=W/2, go to DRAIN.
- Total beats per frame = W/2+1 = 1025. Word 1 is read once only (head beat 1) and never paired.
- rd_addr_c2 and rd_c2_en are 0 on head beats. Addresses are 0 when rd_en=0.
- Data-path outputs: dp_index_col_1=rd_addr_c1, dp_index_col_2=rd_addr_c2 and dp_col2_vld=rd_c2_en, each delayed RD_LAT enabled cycles through a pipeline that advances only when stall=0.
  - dp_valid = pipeline valid AND NOT stall.
  - Index outputs hold their value under stall and are 0 when the pipeline slot is empty.
- Stall, sampled in the same cycle:
  - rd_en=0; B, state and the delay pipeline hold.
  - The beat on the dp_* outputs is not consumed and is re-presented when stall drops.
  - Stall in IDLE or DONE has no effect.
- Latency: first rd_en is 1 cycle after start is accepted. First dp_valid follows RD_LAT cycles later.
- DRAIN: issues no new beats and waits until the pipeline is empty (RD_LAT non-stalled cycles).
- DONE: done=1 for one cycle. IDLE follows.
- start while busy is ignored (start_rdy=0).
- start asserted in the DONE cycle is ignored; it must be re-presented in IDLE.
- Back-to-back frames: minimum gap from done to the next first rd_en is 2 cycles.

Optional Feature:
- Macro RECOVER_CTRL_PERF_EN.
- When defined: adds output port stall_cnt (16 bits).
  - Counts cycles with busy=1 and stall=1; saturates at 0xFFFF.
  - Clears on rst and on each accepted start.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Default params, RD_LAT=1, single start, no stall:
  - First rd_en 1 cycle after start; dp_valid high for 1025 consecutive cycles starting 1 cycle later.
  - Beat indices: 0, 1, then (2,3) ... (2046,2047); dp_col2_vld=0 on the first two beats only.
  - done pulses 1 cycle after the last dp_valid.
- RD_LAT=3:
  - dp_index_col_1 equals the value rd_addr_c1 had 3 enabled cycles earlier for every beat.
  - Data read from x1/x2 matches the golden per-index lanes.
- stall=1 for 5 cycles while beat (100,101) is presented:
  - dp_valid=0 for those 5 cycles and the indices hold.
  - (100,101) is presented exactly once after release; the frame takes 1025+5 cycles of beats.
  - With RECOVER_CTRL_PERF_EN, stall_cnt=5.
- rst=1 for 1 cycle at beat 500:
  - Next cycle: dp_valid=0, busy=0, start_rdy=1, no done pulse.
  - A new start then replays from index 0.
- start held high continuously: two frames run back to back, separated by DRAIN/DONE/IDLE.
  - start pulses while busy are ignored; exactly 2 done pulses in a 2-frame window.
- stall=1 throughout DONE: done still pulses for one cycle.
  - stall=1 in IDLE together with start=1: frame is accepted, then the first beat waits until stall=0.
